// File: rtl/ballot_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ballot_controller: arms one ballot per officer issue, arbitrates candidate |
// | presses into a single one-hot grant, and voids ballots on timeout/mode.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ballot_controller #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CONFIRM_CYCLES = 50,
  parameter int CW             = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mode,
  input  logic          ballot_issue,
  input  logic [3:0]    vote_valid,
  output logic [3:0]    vote_grant,
  output logic          ballot_ready,
  output logic          confirm_busy,
  output logic          reject,
  output logic [CW-1:0] ballots_cast,
  output logic [CW-1:0] ballots_void
);

  localparam int TMAX = (TIMEOUT_CYCLES > CONFIRM_CYCLES) ? TIMEOUT_CYCLES : CONFIRM_CYCLES;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] C_TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] C_CONFIRM_LOAD = TW'(CONFIRM_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CONFIRM = 2'd2,
    S_LOCKED  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [3:0]     grant_q, grant_d;
  logic           ready_q, ready_d;
  logic           busy_q, busy_d;
  logic           reject_q, reject_d;
  logic [CW-1:0]  cast_q, cast_d;
  logic [CW-1:0]  void_q, void_d;

  logic           w_any_press;
  logic           w_single_press;
  logic           w_multi_press;
  logic           w_timer_zero;

  // Counters hold at all-ones rather than wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  assign w_any_press    = |vote_valid;
  assign w_single_press = w_any_press && ((vote_valid & (vote_valid - 4'd1)) == 4'd0);
  assign w_multi_press  = w_any_press && !w_single_press;
  assign w_timer_zero   = (timer_q == '0);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    grant_d  = 4'd0;
    reject_d = 1'b0;
    cast_d   = cast_q;
    void_d   = void_q;

    case (state_q)
      S_IDLE: begin
        if (mode) begin
          state_d = S_LOCKED;
        end else if (ballot_issue) begin
          state_d = S_ARMED;
          timer_d = C_TIMEOUT_LOAD;
        end
      end

      S_ARMED: begin
        if (mode) begin
          state_d = S_LOCKED;
          void_d  = sat_inc(void_q);
        end else if (w_single_press) begin
          // A clean single press beats the timeout even in the last armed cycle.
          grant_d = vote_valid;
          cast_d  = sat_inc(cast_q);
          state_d = S_CONFIRM;
          timer_d = C_CONFIRM_LOAD;
        end else begin
          reject_d = w_multi_press;
          if (w_timer_zero) begin
            state_d = S_IDLE;
            void_d  = sat_inc(void_q);
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
      end

      S_CONFIRM: begin
        if (w_timer_zero) begin
          state_d = mode ? S_LOCKED : S_IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      S_LOCKED: begin
        if (!mode) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status LEDs follow the state being entered so they register with it.
    ready_d = (state_d == S_ARMED);
    busy_d  = (state_d == S_CONFIRM);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      grant_q  <= 4'd0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      reject_q <= 1'b0;
      cast_q   <= '0;
      void_q   <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      grant_q  <= grant_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      reject_q <= reject_d;
      cast_q   <= cast_d;
      void_q   <= void_d;
    end
  end

  assign vote_grant   = grant_q;
  assign ballot_ready = ready_q;
  assign confirm_busy = busy_q;
  assign reject       = reject_q;
  assign ballots_cast = cast_q;
  assign ballots_void = void_q;

endmodule
`default_nettype wire

// File: tb/tb_ballot_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ballot_controller: directed plus random stimulus against a ballot-level |
// | reference model of the voting rules.                                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ballot_controller;

  localparam int TO  = 8;
  localparam int CF  = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  localparam int P_IDLE = 0;
  localparam int P_OPEN = 1;
  localparam int P_HOLD = 2;
  localparam int P_LOCK = 3;

  logic          clk;
  logic          rst_n;
  logic          mode_i;
  logic          issue_i;
  logic [3:0]    vv_i;
  logic [3:0]    vote_grant;
  logic          ballot_ready;
  logic          confirm_busy;
  logic          reject;
  logic [CW-1:0] ballots_cast;
  logic [CW-1:0] ballots_void;

  int total;
  int bad;

  // Reference model: where the ballot is, how long it has been open,
  // how much lockout remains, and the expected registered outputs.
  int   m_phase;
  int   m_age;
  int   m_left;
  int   e_grant;
  int   e_ready;
  int   e_busy;
  int   e_reject;
  int   e_cast;
  int   e_void;

  ballot_controller #(
    .TIMEOUT_CYCLES(TO),
    .CONFIRM_CYCLES(CF),
    .CW            (CW)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .mode        (mode_i),
    .ballot_issue(issue_i),
    .vote_valid  (vv_i),
    .vote_grant  (vote_grant),
    .ballot_ready(ballot_ready),
    .confirm_busy(confirm_busy),
    .reject      (reject),
    .ballots_cast(ballots_cast),
    .ballots_void(ballots_void)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase  = P_IDLE;
    m_age    = 0;
    m_left   = 0;
    e_grant  = 0;
    e_ready  = 0;
    e_busy   = 0;
    e_reject = 0;
    e_cast   = 0;
    e_void   = 0;
  endtask

  task automatic model_step(input bit md, input bit iss, input int vv);
    int presses;
    presses  = $countones(vv[3:0]);
    e_grant  = 0;
    e_reject = 0;
    case (m_phase)
      P_IDLE: begin
        if (md) m_phase = P_LOCK;
        else if (iss) begin
          m_phase = P_OPEN;
          m_age   = 0;
        end
      end
      P_OPEN: begin
        if (md) begin
          m_phase = P_LOCK;
          if (e_void < SAT) e_void++;
        end else if (presses == 1) begin
          e_grant = vv;
          if (e_cast < SAT) e_cast++;
          m_phase = P_HOLD;
          m_left  = CF;
        end else begin
          if (presses >= 2) e_reject = 1;
          if (m_age == TO - 1) begin
            m_phase = P_IDLE;
            if (e_void < SAT) e_void++;
          end else begin
            m_age++;
          end
        end
      end
      P_HOLD: begin
        m_left--;
        if (m_left == 0) m_phase = md ? P_LOCK : P_IDLE;
      end
      default: begin
        if (!md) m_phase = P_IDLE;
      end
    endcase
    e_ready = (m_phase == P_OPEN) ? 1 : 0;
    e_busy  = (m_phase == P_HOLD) ? 1 : 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".grant"},  int'(vote_grant),   e_grant);
    check({tag, ".ready"},  int'(ballot_ready), e_ready);
    check({tag, ".busy"},   int'(confirm_busy), e_busy);
    check({tag, ".reject"}, int'(reject),       e_reject);
    check({tag, ".cast"},   int'(ballots_cast), e_cast);
    check({tag, ".void"},   int'(ballots_void), e_void);
    check({tag, ".onehot"}, ($countones(vote_grant) <= 1) ? 1 : 0, 1);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic tick(input string tag, input bit md, input bit iss, input logic [3:0] vv);
    mode_i  = md;
    issue_i = iss;
    vv_i    = vv;
    @(posedge clk);
    model_step(md, iss, int'(vv));
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  initial begin
    int ready_cycles;
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    mode_i  = 1'b0;
    issue_i = 1'b0;
    vv_i    = 4'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // Normal vote with a press arriving three cycles after the issue.
    tick("vote_issue", 0, 1, 4'b0000);
    tick("vote_wait", 0, 0, 4'b0000);
    tick("vote_wait", 0, 0, 4'b0000);
    tick("vote_press", 0, 0, 4'b0100);
    check("vote_grant_seen", int'(vote_grant), 4);
    tick("vote_confirm_press", 0, 0, 4'b0010);
    repeat (3) tick("vote_confirm", 0, 0, 4'b0000);
    tick("vote_idle", 0, 0, 4'b0000);
    check("vote_cast_one", int'(ballots_cast), 1);

    // Timeout: count how long the ready LED stays lit.
    tick("to_issue", 0, 1, 4'b0000);
    ready_cycles = 0;
    for (int i = 0; i < TO + 2; i++) begin
      if (ballot_ready) ready_cycles++;
      tick("to_wait", 0, 0, 4'b0000);
    end
    check("to_ready_cycles", ready_cycles, TO);
    check("to_void_one", int'(ballots_void), 1);

    // Simultaneous press is rejected, then a clean press is granted.
    tick("sim_issue", 0, 1, 4'b0000);
    tick("sim_double", 0, 0, 4'b0011);
    tick("sim_single", 0, 0, 4'b1000);
    repeat (CF + 1) tick("sim_after", 0, 0, 4'b0000);

    // Press in the final armed cycle beats the timeout.
    tick("race_issue", 0, 1, 4'b0000);
    repeat (TO - 1) tick("race_wait", 0, 0, 4'b0000);
    tick("race_press", 0, 0, 4'b0001);
    check("race_grant", int'(vote_grant), 1);
    check("race_void_same", int'(ballots_void), 1);
    repeat (CF + 1) tick("race_after", 0, 0, 4'b0000);

    // Mode entry while armed voids the ballot; locked ignores everything.
    tick("mode_issue", 0, 1, 4'b0000);
    tick("mode_armed", 0, 0, 4'b0000);
    tick("mode_enter", 1, 0, 4'b0000);
    tick("mode_locked_issue", 1, 1, 4'b0100);
    tick("mode_locked_press", 1, 0, 4'b0001);
    tick("mode_exit", 0, 0, 4'b0000);
    tick("mode_new_issue", 0, 1, 4'b0000);
    tick("mode_new_press", 0, 0, 4'b0010);
    repeat (CF + 1) tick("mode_after", 0, 0, 4'b0000);

    // Randomized traffic with rare mode toggles and mostly quiet keypads.
    for (int i = 0; i < 600; i++) begin
      bit         md;
      bit         iss;
      logic [3:0] vv;
      md  = ($urandom_range(0, 99) < 6);
      iss = ($urandom_range(0, 99) < 25);
      vv  = ($urandom_range(0, 99) < 65) ? 4'd0 : 4'($urandom_range(0, 15));
      tick("rand", md, iss, vv);
    end
    repeat (3) tick("rand_settle", 0, 0, 4'b0000);

    // Saturation: seventeen complete ballots.
    for (int i = 0; i < 17; i++) begin
      logic [3:0] pick;
      pick = 4'b0001 << (i % 4);
      tick("sat_issue", 0, 1, 4'b0000);
      tick("sat_press", 0, 0, pick);
      repeat (CF) tick("sat_confirm", 0, 0, 4'b0000);
    end
    check("sat_cast_hold", int'(ballots_cast), SAT);

    // Asynchronous reset in the middle of an armed ballot.
    tick("rst_issue", 0, 1, 4'b0000);
    tick("rst_armed", 0, 0, 4'b0000);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    tick("rst_after_issue", 0, 1, 4'b0000);
    tick("rst_after_press", 0, 0, 4'b0100);
    repeat (CF + 1) tick("rst_after", 0, 0, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ballot_controller.md
Name: ballot_controller

Overview:
- Sequences the voting unit so one issued ballot yields at most one counted vote.
- Sits between the four debounced per-candidate valid pulses and the vote logger.
- Arms the unit when the presiding officer issues a ballot, and arbitrates the candidate pulses.
- Forwards exactly one one-hot grant to the logger, holds a confirm lockout, and voids ballots on timeout or result-mode entry.

Parameters:
- TIMEOUT_CYCLES, 1000, cycles a ballot stays armed before it is voided (>=2).
- CONFIRM_CYCLES, 50, cycles of post-vote lockout with confirm indicator (>=1).
- CW, 8, width of the ballot statistics counters.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 forces reset state immediately.
- mode  in  1  0 = voting, 1 = result display; voting is blocked while 1.
- ballot_issue  in  1  single-cycle pulse from the officer to issue one ballot.
- vote_valid  in  4  per-candidate debounced single-cycle vote pulses; bit i = candidate i+1.
- vote_grant  out  4  one-hot single-cycle pulse to the logger; only source of counted votes.
- ballot_ready  out  1  high while a ballot is armed (voter LED).
- confirm_busy  out  1  high during the post-vote lockout.
- reject  out  1  single-cycle pulse on a multi-candidate press while armed.
- ballots_cast  out  CW  count of granted votes.
- ballots_void  out  CW  count of ballots voided by timeout or mode entry.

Behaviour:
- Reset values: state IDLE, all outputs 0, timers 0.
- All outputs are registered.
- States: IDLE, ARMED, CONFIRM, LOCKED.
- IDLE:
  - mode=1 -> LOCKED.
  - Otherwise ballot_issue=1 -> ARMED, with the timeout timer loaded to TIMEOUT_CYCLES-1.
  - vote_valid is ignored.
- ARMED (ballot_ready=1): checks are evaluated each cycle in this priority order.
  1. mode=1 -> LOCKED; ballots_void+1.
  2. Exactly one vote_valid bit set -> vote_grant=that bit on the next cycle for one cycle; ballots_cast+1 on the same edge; -> CONFIRM with the confirm timer loaded to CONFIRM_CYCLES-1.
  3. Two or more bits set -> reject=1 next cycle for one cycle; stay ARMED; no grant; the timer keeps running.
  4. Timer==0 -> IDLE; ballots_void+1.
  5. Otherwise the timer decrements.
- ARMED therefore lasts at most TIMEOUT_CYCLES cycles.
- A valid single press in the final armed cycle wins over the timeout.
- CONFIRM (confirm_busy=1 for exactly CONFIRM_CYCLES cycles):
  - The timer decrements each cycle; at 0 -> IDLE, or LOCKED if mode=1.
  - vote_valid and ballot_issue are ignored; mode does not abort the lockout.
- LOCKED: all inputs except mode are ignored; mode=0 -> IDLE.
- ballot_issue in any state other than IDLE is ignored and not queued.
- Latency:
  - Issue sampled at cycle N -> ballot_ready=1 from N+1.
  - Single press sampled at cycle M -> vote_grant and ballots_cast update at M+1; confirm_busy from M+1 to M+CONFIRM_CYCLES; ballot_ready drops at M+1.
- Counters saturate at 2^CW-1; they never wrap. They are cleared only by reset.
- At most one vote_grant bit is ever set. Grants occur only from ARMED. The number of grants equals the number of ballots_cast increments, unless ballots_cast has saturated.
- Reset asserted mid-operation aborts everything: no grant is emitted, and the void counter is not incremented.

Test Plan:
(TIMEOUT_CYCLES=8, CONFIRM_CYCLES=4, CW=4)
- Normal vote: ballot_issue, then vote_valid=0100 three cycles later -> vote_grant=0100 for 1 cycle; ballots_cast=1; confirm_busy high for 4 cycles; then IDLE; a second vote_valid during confirm produces no grant.
- Timeout: ballot_issue, no press -> ballot_ready high for exactly 8 cycles; then ballots_void=1, ballots_cast=0.
- Simultaneous press: while armed, vote_valid=0011 -> reject pulse and no grant; then vote_valid=1000 -> vote_grant=1000; ballots_cast=1.
- Last-cycle race: press vote_valid=0001 in the 8th armed cycle -> grant issued; ballots_void unchanged.
- Mode handling: mode=1 while armed -> LOCKED; ballots_void+1; ballot_issue and presses are ignored while locked. mode=0 -> IDLE; a new ballot then works normally.
- Saturation and reset: 17 consecutive ballot/vote sequences -> ballots_cast holds at 15. Asserting reset low mid-ARMED clears all outputs asynchronously.
